// File: rtl/camera_power_manager.sv
// Request-driven power sequencer for the image sensor: 1V2/1V8/3V3 rails, XCLR, INCK_EN.
// Define CAM_PGOOD_CHECK_EN to enable power-good synchronizers, up-step timeout and brown-out faults.
module camera_power_manager #(
  parameter logic [31:0] STEP_DELAY    = 32'd1000000,
  parameter logic [31:0] PGOOD_TIMEOUT = 32'd2000000
) (
  input  logic ctrl_clk_i,
  input  logic ctrl_rst_n_i,
  input  logic pwr_en_i,
  input  logic fault_clr_i,
  input  logic pgood_1v2_i,
  input  logic pgood_1v8_i,
  input  logic pgood_3v3_i,
  output logic reg_1v2_en_o,
  output logic reg_1v8_en_o,
  output logic reg_3v3_en_o,
  output logic xclr_o,
  output logic inck_en_o,
  output logic ready_o,
  output logic busy_o,
  output logic fault_o
);

  // state      | meaning
  // OFF / ON   | everything off / sensor fully powered
  // UP_x, DN_x | output x being raised / dropped, dwelling at least STEP_DELAY+1 cycles
  // FAULT      | all outputs dropped, held until fault_clr_i with pwr_en_i low
  typedef enum logic [3:0] {
    S_OFF     = 4'd0,
    S_UP_1V2  = 4'd1,
    S_UP_1V8  = 4'd2,
    S_UP_3V3  = 4'd3,
    S_UP_XCLR = 4'd4,
    S_UP_INCK = 4'd5,
    S_ON      = 4'd6,
    S_DN_INCK = 4'd7,
    S_DN_XCLR = 4'd8,
    S_DN_3V3  = 4'd9,
    S_DN_1V8  = 4'd10,
    S_DN_1V2  = 4'd11,
    S_FAULT   = 4'd12
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [4:0]  rails_q, rails_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        fault_q, fault_d;
  logic [2:0]  pgood_s;
  logic        step_done;
  logic        timed_out;

`ifdef CAM_PGOOD_CHECK_EN
  localparam bit PGOOD_CHECK = 1'b1;
  logic [2:0] pgood_meta_q;
  logic [2:0] pgood_sync_q;

  always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i) begin
    if (!ctrl_rst_n_i) begin
      pgood_meta_q <= '0;
      pgood_sync_q <= '0;
    end else begin
      pgood_meta_q <= {pgood_3v3_i, pgood_1v8_i, pgood_1v2_i};
      pgood_sync_q <= pgood_meta_q;
    end
  end

  assign pgood_s = pgood_sync_q;
`else
  localparam bit PGOOD_CHECK = 1'b0;
  logic unused_pgood;

  assign unused_pgood = ^{pgood_3v3_i, pgood_1v8_i, pgood_1v2_i};
  assign pgood_s      = 3'b111;
`endif

  assign step_done = (count_q >= STEP_DELAY);
  assign timed_out = (count_q >= PGOOD_TIMEOUT);

  always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i) begin
    if (!ctrl_rst_n_i) begin
      state_q <= S_OFF;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Abort is tested first in every UP step so it wins over advance and timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:     if (pwr_en_i) state_d = S_UP_1V2;
      S_UP_1V2: begin
        if (!pwr_en_i)                     state_d = S_DN_1V2;
        else if (pgood_s[0] && step_done)  state_d = S_UP_1V8;
        else if (PGOOD_CHECK && timed_out) state_d = S_FAULT;
      end
      S_UP_1V8: begin
        if (!pwr_en_i)                     state_d = S_DN_1V8;
        else if (pgood_s[1] && step_done)  state_d = S_UP_3V3;
        else if (PGOOD_CHECK && timed_out) state_d = S_FAULT;
      end
      S_UP_3V3: begin
        if (!pwr_en_i)                     state_d = S_DN_3V3;
        else if (pgood_s[2] && step_done)  state_d = S_UP_XCLR;
        else if (PGOOD_CHECK && timed_out) state_d = S_FAULT;
      end
      S_UP_XCLR: begin
        if (!pwr_en_i)      state_d = S_DN_XCLR;
        else if (step_done) state_d = S_UP_INCK;
      end
      S_UP_INCK: begin
        if (!pwr_en_i)      state_d = S_DN_INCK;
        else if (step_done) state_d = S_ON;
      end
      S_ON: begin
        if (PGOOD_CHECK && !(&pgood_s)) state_d = S_FAULT;
        else if (!pwr_en_i)             state_d = S_DN_INCK;
      end
      S_DN_INCK: if (step_done) state_d = S_DN_XCLR;
      S_DN_XCLR: if (step_done) state_d = S_DN_3V3;
      S_DN_3V3:  if (step_done) state_d = S_DN_1V8;
      S_DN_1V8:  if (step_done) state_d = S_DN_1V2;
      S_DN_1V2:  if (step_done) state_d = S_OFF;
      S_FAULT:   if (fault_clr_i && !pwr_en_i) state_d = S_OFF;
      default:   state_d = S_FAULT;
    endcase
  end

  always_comb begin
    if (state_d != state_q) count_d = '0;
    else                    count_d = count_q + 32'd1;
  end

  // rails_d bit order, LSB first: 1V2, 1V8, 3V3, XCLR, INCK (the up order).
  always_comb begin
    rails_d = '0;
    ready_d = 1'b0;
    busy_d  = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      S_UP_1V2:  begin rails_d = 5'b00001; busy_d = 1'b1; end
      S_UP_1V8:  begin rails_d = 5'b00011; busy_d = 1'b1; end
      S_UP_3V3:  begin rails_d = 5'b00111; busy_d = 1'b1; end
      S_UP_XCLR: begin rails_d = 5'b01111; busy_d = 1'b1; end
      S_UP_INCK: begin rails_d = 5'b11111; busy_d = 1'b1; end
      S_ON:      begin rails_d = 5'b11111; ready_d = 1'b1; end
      S_DN_INCK: begin rails_d = 5'b01111; busy_d = 1'b1; end
      S_DN_XCLR: begin rails_d = 5'b00111; busy_d = 1'b1; end
      S_DN_3V3:  begin rails_d = 5'b00011; busy_d = 1'b1; end
      S_DN_1V8:  begin rails_d = 5'b00001; busy_d = 1'b1; end
      S_DN_1V2:  begin rails_d = 5'b00000; busy_d = 1'b1; end
      S_FAULT:   fault_d = 1'b1;
      default:   rails_d = '0;
    endcase
  end

  always_ff @(posedge ctrl_clk_i or negedge ctrl_rst_n_i) begin
    if (!ctrl_rst_n_i) begin
      rails_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      rails_q <= rails_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign reg_1v2_en_o = rails_q[0];
  assign reg_1v8_en_o = rails_q[1];
  assign reg_3v3_en_o = rails_q[2];
  assign xclr_o       = rails_q[3];
  assign inck_en_o    = rails_q[4];
  assign ready_o      = ready_q;
  assign busy_o       = busy_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_camera_power_manager.sv
// Scoreboard bench for camera_power_manager: randomized power scenarios against an event-level model.
module tb_camera_power_manager;

  localparam int STEP     = 5;   // STEP_DELAY + 1
  localparam int RAIL_MAX = 11;  // PGOOD_TIMEOUT + 1
  localparam logic [7:0] V_OFF   = 8'h00;
  localparam logic [7:0] V_ON    = 8'h3F;
  localparam logic [7:0] V_FAULT = 8'h80;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pwr_en = 1'b0;
  logic fault_clr = 1'b0;
  logic [2:0] pg_d1 = '0;
  logic [2:0] pg_d2 = '0;
  logic [2:0] pg_force = '0;
  logic pgood_1v2, pgood_1v8, pgood_3v3;
  logic en_1v2, en_1v8, en_3v3, xclr, inck, ready, busy, fault;
  logic [7:0] outvec;
  logic [4:0] rails;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tag_n = 0;

  typedef struct {
    logic [7:0] vec;
    bit         rel;
    int         lo;
    int         hi;
    int         t0;
    int         tag;
  } exp_t;
  exp_t q[$];

  camera_power_manager #(
    .STEP_DELAY   (32'd4),
    .PGOOD_TIMEOUT(32'd10)
  ) dut (
    .ctrl_clk_i   (clk),
    .ctrl_rst_n_i (rst_n),
    .pwr_en_i     (pwr_en),
    .fault_clr_i  (fault_clr),
    .pgood_1v2_i  (pgood_1v2),
    .pgood_1v8_i  (pgood_1v8),
    .pgood_3v3_i  (pgood_3v3),
    .reg_1v2_en_o (en_1v2),
    .reg_1v8_en_o (en_1v8),
    .reg_3v3_en_o (en_3v3),
    .xclr_o       (xclr),
    .inck_en_o    (inck),
    .ready_o      (ready),
    .busy_o       (busy),
    .fault_o      (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Regulator model: power-good follows its enable two cycles late, unless forced low.
  always @(posedge clk) begin
    pg_d1 <= {en_3v3, en_1v8, en_1v2};
    pg_d2 <= pg_d1;
  end
  assign pgood_1v2 = pg_d2[0] & ~pg_force[0];
  assign pgood_1v8 = pg_d2[1] & ~pg_force[1];
  assign pgood_3v3 = pg_d2[2] & ~pg_force[2];

  assign rails  = {inck, xclr, en_3v3, en_1v8, en_1v2};
  assign outvec = {fault, busy, ready, rails};

  // Expected output vectors: {fault, busy, ready, rails}; n outputs on in up order form a thermometer.
  function automatic logic [4:0] thermo(input int n);
    int t;
    t = (1 << n) - 1;
    return t[4:0];
  endfunction
  function automatic logic [7:0] v_up(input int k);   // UP step that raises output k-1
    return {3'b010, thermo(k)};
  endfunction
  function automatic logic [7:0] v_dn(input int x);   // DN step that drops output x
    return {3'b010, thermo(x)};
  endfunction

  task automatic push(input logic [7:0] v, input bit rel, input int lo, input int hi);
    exp_t e;
    e.vec = v; e.rel = rel; e.lo = lo; e.hi = hi; e.t0 = cyc; e.tag = tag_n;
    tag_n++;
    q.push_back(e);
  endtask

  // Monitor: every change of the output vector is one DUT event, matched against the queue head.
  logic [7:0] last_vec = 8'h00;
  int last_chg = 0;
  always @(negedge clk) begin
    logic [7:0] cur;
    int el;
    exp_t e;
    cur = outvec;
    if (cur !== last_vec) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %h, required no change (cycle %0d)", cur, cyc);
      end else begin
        e = q.pop_front();
        el = e.rel ? cyc - e.t0 : cyc - last_chg;
        if (cur !== e.vec || el < e.lo || el > e.hi) begin
          errors++;
          $display("FAIL event%0d: got %h after %0d cycles, required %h after %0d..%0d cycles",
                   e.tag, cur, el, e.vec, e.lo, e.hi);
        end
      end
      last_vec = cur;
      last_chg = cyc;
    end else if (q.size() != 0) begin
      el = q[0].rel ? cyc - q[0].t0 : cyc - last_chg;
      if (el > q[0].hi) begin
        checks++;
        errors++;
        $display("FAIL event%0d_late: still %h after %0d cycles, required %h within %0d",
                 q[0].tag, cur, el, q[0].vec, q[0].hi);
        e = q.pop_front();
        last_chg = cyc;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic bit cond(input int sel);
    if (sel == 0) return ready;
    if (sel == 1) return fault;
    if (sel == 2) return q.size() == 0;
    if (sel >= 20) return !rails[sel-20];
    return rails[sel-10];
  endfunction

  task automatic wait_for(input int sel);
    int n;
    n = 0;
    while (!cond(sel)) begin
      step();
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL wait_cond%0d: got 0 after 300 cycles, required 1", sel);
        q.delete();
        return;
      end
    end
  endtask

  task automatic push_up();
    push(v_up(1), 1'b1, 2, 2);
    for (int k = 2; k <= 4; k++) push(v_up(k), 1'b0, STEP, RAIL_MAX);
    push(v_up(5), 1'b0, STEP, STEP);
    push(V_ON, 1'b0, STEP, STEP);
  endtask

  task automatic power_down(input bit rereq);
    pwr_en = 1'b0;
    push(v_dn(4), 1'b1, 2, 2);
    for (int x = 3; x >= 0; x--) push(v_dn(x), 1'b0, STEP, STEP);
    push(V_OFF, 1'b0, STEP, STEP);
    if (rereq) begin
      wait_for(22);
      pwr_en = 1'b1;
      step();
      step();
      pwr_en = 1'b0;
    end
    wait_for(2);
  endtask

  task automatic full_cycle(input bit rereq);
    pwr_en = 1'b1;
    push_up();
    wait_for(2);
    repeat ($urandom_range(0, 5)) step();
    power_down(rereq);
  endtask

  task automatic abort_at(input int k);
    int r;
    r = k - 1;
    pwr_en = 1'b1;
    push_up();
    wait_for(10 + r);
    q.delete();
    pwr_en = 1'b0;
    push(v_dn(r), 1'b1, 2, 2);
    for (int x = r - 1; x >= 0; x--) push(v_dn(x), 1'b0, STEP, STEP);
    push(V_OFF, 1'b0, STEP, STEP);
    wait_for(2);
  endtask

  task automatic timeout_at(input int r);
    pg_force[r] = 1'b1;
    pwr_en = 1'b1;
`ifdef CAM_PGOOD_CHECK_EN
    push(v_up(1), 1'b1, 2, 2);
    for (int k = 2; k <= r + 1; k++) push(v_up(k), 1'b0, STEP, RAIL_MAX);
    push(V_FAULT, 1'b0, RAIL_MAX, RAIL_MAX);
    wait_for(2);
    fault_clr = 1'b1;
    repeat (4) step();
    pwr_en = 1'b0;
    push(V_OFF, 1'b1, 2, 2);
    wait_for(2);
    fault_clr = 1'b0;
    pg_force[r] = 1'b0;
`else
    push_up();
    wait_for(2);
    pg_force[r] = 1'b0;
    power_down(1'b0);
`endif
  endtask

  task automatic brownout_at(input int r);
    pwr_en = 1'b1;
    push_up();
    wait_for(2);
    pg_force[r] = 1'b1;
`ifdef CAM_PGOOD_CHECK_EN
    push(V_FAULT, 1'b1, 4, 4);
`endif
    repeat (3) step();
    pg_force[r] = 1'b0;
`ifdef CAM_PGOOD_CHECK_EN
    wait_for(2);
    fault_clr = 1'b1;
    pwr_en = 1'b0;
    push(V_OFF, 1'b1, 2, 2);
    wait_for(2);
    fault_clr = 1'b0;
`else
    repeat (4) step();
    power_down(1'b0);
`endif
  endtask

  task automatic reset_mid();
    pwr_en = 1'b1;
    push_up();
    wait_for(13);
    q.delete();
    rst_n = 1'b0;
    #1;
    checks++;
    if (outvec !== V_OFF) begin
      errors++;
      $display("FAIL async_reset: got %h, required %h", outvec, V_OFF);
    end
    push(V_OFF, 1'b1, 0, 1);
    repeat (3) step();
    rst_n = 1'b1;
    push_up();
    wait_for(2);
    power_down(1'b0);
  endtask

  initial begin
    int sel;
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if (outvec !== V_OFF) begin
      errors++;
      $display("FAIL reset_state: got %h, required %h", outvec, V_OFF);
    end
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (outvec !== V_OFF) begin
      errors++;
      $display("FAIL idle_off: got %h, required %h", outvec, V_OFF);
    end

    full_cycle(1'b1);
    abort_at(3);
    timeout_at(1);
    brownout_at(2);
    reset_mid();
    abort_at(1);
    abort_at(5);

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 6)) step();
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       full_cycle(1'($urandom_range(0, 1)));
        1:       abort_at(int'($urandom_range(1, 5)));
        2:       timeout_at(int'($urandom_range(0, 2)));
        3:       brownout_at(int'($urandom_range(0, 2)));
        default: reset_mid();
      endcase
    end

    repeat (8) step();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_events: got %0d pending, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
